// File: rtl/et_err_serializer.sv
// Frames parallel TLK/DC error words onto a single serial error line:
// 3-bit type header (MSB first), payload LSB first, zero idle and a fixed inter-frame gap.
module et_err_serializer #(
    parameter int LENGTH_ERR_TLK = 18,
    parameter int LENGTH_ERR_DC  = 20,
    parameter int GAP_BITS       = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_live,
    input  logic [LENGTH_ERR_TLK-1:0] tlk_err_bus,
    input  logic                      tlk_valid,
    output logic                      tlk_ready,
    input  logic [LENGTH_ERR_DC-1:0]  dc_err_bus,
    input  logic                      dc_valid,
    output logic                      dc_ready,
    output logic                      out_err,
    output logic                      busy,
    output logic                      tlk_sent,
    output logic                      dc_sent,
    output logic                      ovf
);

    localparam int LEN_MAX = (LENGTH_ERR_DC > LENGTH_ERR_TLK) ? LENGTH_ERR_DC : LENGTH_ERR_TLK;
    localparam int PCW     = $clog2(LEN_MAX);
    localparam int GCW     = $clog2(GAP_BITS);

    localparam logic [PCW-1:0] TLK_LAST = PCW'(LENGTH_ERR_TLK - 1);
    localparam logic [PCW-1:0] DC_LAST  = PCW'(LENGTH_ERR_DC - 1);
    localparam logic [GCW-1:0] GAP_LAST = GCW'(GAP_BITS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HDR  = 2'd1;
    localparam logic [1:0] S_PAY  = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    logic [1:0]                r_state;
    logic [1:0]                r_hdr_cnt;
    logic [PCW-1:0]            r_pay_cnt;
    logic [GCW-1:0]            r_gap_cnt;
    logic                      r_is_dc;
    logic [LEN_MAX-1:0]        r_shift;
    logic                      r_out_err;
    logic                      r_tlk_sent;
    logic                      r_dc_sent;
    logic                      r_ovf;
    logic [LENGTH_ERR_TLK-1:0] r_tlk_hold;
    logic                      r_tlk_pend;
    logic [LENGTH_ERR_DC-1:0]  r_dc_hold;
    logic                      r_dc_pend;

    logic [1:0]         w_state_next;
    logic [1:0]         w_hdr_cnt_next;
    logic [PCW-1:0]     w_pay_cnt_next;
    logic [GCW-1:0]     w_gap_cnt_next;
    logic               w_is_dc_next;
    logic [LEN_MAX-1:0] w_shift_next;
    logic               w_out_next;
    logic               w_last_next;
    logic [PCW-1:0]     w_pay_last;
    logic               w_load_slot;
    logic               w_load_dc;
    logic               w_load_tlk;
    logic               w_load;
    logic               w_tlk_acc;
    logic               w_dc_acc;

    assign w_pay_last  = r_is_dc ? DC_LAST : TLK_LAST;
    // A frame may start from IDLE or directly out of the last gap cycle.
    assign w_load_slot = (r_state == S_IDLE) | ((r_state == S_GAP) & (r_gap_cnt == GAP_LAST));
    assign w_load_dc   = in_live & w_load_slot & r_dc_pend;
    assign w_load_tlk  = in_live & w_load_slot & ~r_dc_pend & r_tlk_pend;
    assign w_load      = w_load_dc | w_load_tlk;

    // Loading frees the holding register on the same edge, so a new word is not blocked.
    assign w_tlk_acc   = in_live & tlk_valid & (~r_tlk_pend | w_load_tlk);
    assign w_dc_acc    = in_live & dc_valid & (~r_dc_pend | w_load_dc);

    always_comb begin
        w_state_next   = r_state;
        w_hdr_cnt_next = r_hdr_cnt;
        w_pay_cnt_next = r_pay_cnt;
        w_gap_cnt_next = r_gap_cnt;
        w_is_dc_next   = r_is_dc;
        w_shift_next   = r_shift;
        w_out_next     = 1'b0;
        w_last_next    = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_state_next = S_IDLE;
            end
            S_HDR: begin
                if (r_hdr_cnt == 2'd2) begin
                    w_state_next   = S_PAY;
                    w_pay_cnt_next = '0;
                    w_out_next     = r_shift[0];
                    w_shift_next   = {1'b0, r_shift[LEN_MAX-1:1]};
                    w_last_next    = (w_pay_last == '0);
                end else begin
                    w_hdr_cnt_next = r_hdr_cnt + 2'd1;
                    w_out_next     = (r_hdr_cnt == 2'd1) & r_is_dc;
                end
            end
            S_PAY: begin
                if (r_pay_cnt == w_pay_last) begin
                    w_state_next   = S_GAP;
                    w_gap_cnt_next = '0;
                end else begin
                    w_pay_cnt_next = PCW'(r_pay_cnt + 1'b1);
                    w_out_next     = r_shift[0];
                    w_shift_next   = {1'b0, r_shift[LEN_MAX-1:1]};
                    w_last_next    = (PCW'(r_pay_cnt + 1'b1) == w_pay_last);
                end
            end
            S_GAP: begin
                if (r_gap_cnt == GAP_LAST) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_gap_cnt_next = GCW'(r_gap_cnt + 1'b1);
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        if (w_load) begin
            w_state_next   = S_HDR;
            w_hdr_cnt_next = 2'd0;
            w_is_dc_next   = w_load_dc;
            w_shift_next   = w_load_dc ? LEN_MAX'(r_dc_hold) : LEN_MAX'(r_tlk_hold);
            w_out_next     = 1'b1;
        end

        // Link down abandons everything, including a partial frame.
        if (!in_live) begin
            w_state_next   = S_IDLE;
            w_hdr_cnt_next = '0;
            w_pay_cnt_next = '0;
            w_gap_cnt_next = '0;
            w_is_dc_next   = 1'b0;
            w_out_next     = 1'b0;
            w_last_next    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_hdr_cnt  <= '0;
            r_pay_cnt  <= '0;
            r_gap_cnt  <= '0;
            r_is_dc    <= 1'b0;
            r_shift    <= '0;
            r_out_err  <= 1'b0;
            r_tlk_sent <= 1'b0;
            r_dc_sent  <= 1'b0;
            r_ovf      <= 1'b0;
            r_tlk_hold <= '0;
            r_tlk_pend <= 1'b0;
            r_dc_hold  <= '0;
            r_dc_pend  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_hdr_cnt  <= w_hdr_cnt_next;
            r_pay_cnt  <= w_pay_cnt_next;
            r_gap_cnt  <= w_gap_cnt_next;
            r_is_dc    <= w_is_dc_next;
            r_shift    <= w_shift_next;
            r_out_err  <= w_out_next;
            r_tlk_sent <= w_last_next & ~r_is_dc;
            r_dc_sent  <= w_last_next & r_is_dc;
            if (w_tlk_acc) begin
                r_tlk_hold <= tlk_err_bus;
            end
            if (w_dc_acc) begin
                r_dc_hold <= dc_err_bus;
            end
            r_tlk_pend <= in_live & ((r_tlk_pend & ~w_load_tlk) | w_tlk_acc);
            r_dc_pend  <= in_live & ((r_dc_pend & ~w_load_dc) | w_dc_acc);
            r_ovf      <= in_live & (r_ovf | (tlk_valid & ~w_tlk_acc) | (dc_valid & ~w_dc_acc));
        end
    end

    assign tlk_ready = in_live & ~r_tlk_pend;
    assign dc_ready  = in_live & ~r_dc_pend;
    assign out_err   = r_out_err;
    assign busy      = (r_state != S_IDLE);
    assign tlk_sent  = r_tlk_sent;
    assign dc_sent   = r_dc_sent;
    assign ovf       = r_ovf;

endmodule

// File: doc/et_err_serializer.md
# et_err_serializer

Upstream framing stage for the serial error line of the fanout CDT. The block accepts parallel TLK error words (18 bit) and DC error words (20 bit) from the local error collectors. It serializes each word onto the single-bit error line that the downstream error deframer samples. Each frame is a 3-bit header, MSB first (TLK = 1,0,0; DC = 1,0,1), followed by the payload LSB first, with zero-level idle and a guaranteed gap between frames.

## Interface
- LENGTH_ERR_TLK, 18, TLK payload bits (no header)
- LENGTH_ERR_DC, 20, DC payload bits (no header)
- GAP_BITS, 4, minimum zero bits between consecutive frames (≥3)
- clk  in  1  system clock; all logic on posedge
- rst_n  in  1  reset; asynchronous, active-low
- in_live  in  1  link enable; low = synchronous flush
- tlk_err_bus  in  LENGTH_ERR_TLK  TLK word
- tlk_valid  in  1  TLK word offered
- tlk_ready  out  1  TLK holding register free
- dc_err_bus  in  LENGTH_ERR_DC  DC word
- dc_valid  in  1  DC word offered
- dc_ready  out  1  DC holding register free
- out_err  out  1  serial error line, registered
- busy  out  1  FSM not in IDLE
- tlk_sent  out  1  one-cycle pulse, last TLK payload bit on line
- dc_sent  out  1  one-cycle pulse, last DC payload bit on line
- ovf  out  1  sticky: valid asserted while corresponding ready low

## Operation
- Storage:
  - One holding register plus pending flag per type.
  - One shared 20-bit shift register.
  - Header counter 0..2, payload counter 0..LENGTH-1, gap counter 0..GAP_BITS-1.
- Acceptance:
  - tlk_ready = in_live & ~tlk_pending. dc_ready is formed the same way.
  - On valid & ready the word is captured and the pending flag is set.
  - When valid & ~ready, the word is dropped and ovf is set. ovf clears only on reset or when in_live is low.
- FSM states: IDLE, HDR, PAY, GAP.
  - IDLE: out_err=0. If any flag is pending, select the type, copy its holding register into the shift register, clear that pending flag, and go to HDR. DC has priority when both are pending.
  - HDR: drive header bits 1, 0, then 0 (TLK) or 1 (DC), one per cycle. After the third bit go to PAY.
  - PAY: drive shift-register bit 0 and shift right. After LENGTH bits go to GAP. The pulse tlk_sent or dc_sent coincides with the last bit.
  - GAP: out_err=0 for GAP_BITS cycles.
    - On the final gap cycle, if a flag is pending, load and go directly to HDR. Back-to-back frames are therefore separated by exactly GAP_BITS zeros.
    - Otherwise go to IDLE.
- Capture vs. load:
  - A word offered on the same edge its type is loaded goes to the holding register. It is not lost, because the pending flag is cleared and the capture is not blocked.
  - A same-type word may be accepted while its previous frame is still transmitting.
- in_live low (synchronous flush), mid-frame included:
  - FSM goes to IDLE; pending flags, counters and ovf clear; out_err=0; ready=0.
  - A partial frame is abandoned; no sent pulse.
- rst_n low (asynchronous) applies the same values immediately, regardless of clk.

## Timing
- Reset values:
  - out_err=0, busy=0, tlk_sent=0, dc_sent=0, ovf=0.
  - tlk_ready=0 and dc_ready=0 while in_live is low, otherwise 1.
- Latency, from an idle machine:
  - Word sampled at edge E0; pending visible after E0.
  - At E1 the FSM loads; the first header bit is on out_err after E1.
  - Payload bit 0 appears after E1+3.
- Frame length on the line:
  - TLK: 21 cycles (3 + 18).
  - DC: 23 cycles (3 + 20).
- tlk_ready or dc_ready:
  - Falls the cycle after acceptance.
  - Rises the cycle after the load edge.
- busy is high from the cycle after the load edge until the FSM returns to IDLE.
- in_live or rst_n asserted on any cycle: the next out_err value is 0.

## Test plan
- TLK single frame:
  - Stimulus: tlk_err_bus=18'h25A5A, one-cycle valid.
  - Required out_err: 1,0,0, then 0,1,0,1,1,0,1,0,0,1,0,1,1,0,1,0,0,1.
  - tlk_sent high on the last bit, then zeros.
- DC single frame:
  - Stimulus: dc_err_bus=20'h00003.
  - Required out_err: 1,0,1,1,1, then eighteen 0s.
  - dc_sent pulses on the 23rd bit; busy covers 23+GAP_BITS cycles.
- Simultaneous valid:
  - Stimulus: TLK=18'h3FFFF and DC=20'hFFFFF on the same edge.
  - Required: DC frame first, exactly 4 zeros, then TLK frame.
  - Both ready signals are low until their own frames load.
- Overflow and queueing:
  - Stimulus: a second TLK word while tlk_pending is set.
  - Required: ovf=1, the second word is dropped, and the first frame is intact.
  - A third word accepted during that frame is sent after the gap.
- Mid-frame flush:
  - Stimulus: drop in_live during payload bit 7 of a DC frame.
  - Required: out_err=0 the next cycle; no dc_sent; ready low.
  - After in_live returns, a new DC word is serialized cleanly.
- Async reset:
  - Stimulus: assert rst_n between clock edges during HDR.
  - Required: outputs reach reset values immediately, before the next clk edge.
